// File: rtl/systolic_skew_feeder_pkg.sv
// Shared definitions for the systolic skew feeder: FSM state encoding and
// the default array geometry shared with the FIFO stage and the PE array.
package systolic_skew_feeder_pkg;

    localparam int LANES_DEF = 5;
    localparam int DW_DEF    = 32;
    localparam int LEN_DEF   = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

endpackage

// File: rtl/systolic_skew_feeder_if.sv
// Bundle between the controller/FIFO stage, the skew feeder and the array
// rows. The feeder side uses the slave modport.
interface systolic_skew_feeder_if
    import systolic_skew_feeder_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int DW    = DW_DEF
);

    logic                  start;
    logic                  com;
    logic [LANES-1:0]      rd_en;
    logic [LANES*DW-1:0]   fifo_data;
    logic [LANES*DW-1:0]   arr_data;
    logic [LANES-1:0]      arr_valid;
    logic                  busy;
    logic                  done;

    modport master (
        output start, com, fifo_data,
        input  rd_en, arr_data, arr_valid, busy, done
    );

    modport slave (
        input  start, com, fifo_data,
        output rd_en, arr_data, arr_valid, busy, done
    );

endinterface

// File: rtl/systolic_skew_feeder_skew_lane.sv
// One lane of the skew feeder: decides whether this lane reads its FIFO at
// step t, then aligns the FIFO read latency and registers the (zero-padded)
// operand toward its array row.
module skew_lane
    import systolic_skew_feeder_pkg::*;
#(
    parameter int IDX = 0,
    parameter int LEN = LEN_DEF,
    parameter int DW  = DW_DEF,
    parameter int CW  = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic [CW-1:0] t,
    input  logic [DW-1:0] fifo_data,
    output logic          rd_en,
    output logic [DW-1:0] arr_data,
    output logic          arr_valid
);

    localparam logic [CW-1:0] LO    = CW'(IDX);
    localparam logic [CW-1:0] LEN_C = CW'(LEN);

    logic rd_d;

    // Window IDX <= t < IDX+LEN as one unsigned compare: when t < IDX the
    // CW-bit difference wraps to at least 2^CW-(LANES-1) >= LEN, so it fails.
    assign rd_en = run && ((t - LO) < LEN_C);

    // Read-latency alignment and the operand register toward the array row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_d      <= 1'b0;
            arr_valid <= 1'b0;
            arr_data  <= '0;
        end else begin
            // NOTE: non-blocking so arr_valid takes the old rd_d, giving the
            // intended two-stage delay instead of collapsing it to one.
            rd_d      <= rd_en;
            arr_valid <= rd_d;
            arr_data  <= rd_d ? fifo_data : '0;
        end
    end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Skew feeder top: waits for load-complete, steps through the staggered
// read schedule, drains the lane pipelines and pulses done.
module systolic_skew_feeder
    import systolic_skew_feeder_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int DW    = DW_DEF,
    parameter int LEN   = LEN_DEF,
    parameter int CW    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    systolic_skew_feeder_if.slave  bus
);

    localparam logic [CW-1:0] T_LAST = CW'(LEN + LANES - 2);

    state_t        state, state_nx;
    logic [CW-1:0] t, t_nx;
    logic          drain_cnt, drain_nx;
    logic          run;

    logic [LANES-1:0]    rd_en_w;
    logic [LANES-1:0]    arr_valid_w;
    logic [LANES*DW-1:0] arr_data_w;

    // State, step counter and drain counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            t         <= '0;
            drain_cnt <= 1'b0;
        end else begin
            state     <= state_nx;
            t         <= t_nx;
            drain_cnt <= drain_nx;
        end
    end

    // Next-state logic: start is only looked at in IDLE, com only before RUN.
    always_comb begin
        // NOTE: every variable gets a default before the case so no branch
        // can leave one unassigned and infer a latch.
        state_nx = state;
        t_nx     = t;
        drain_nx = drain_cnt;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    state_nx = bus.com ? S_RUN : S_WAIT;
                    t_nx     = '0;
                end
            end
            S_WAIT: begin
                if (bus.com) begin
                    state_nx = S_RUN;
                    t_nx     = '0;
                end
            end
            S_RUN: begin
                if (t == T_LAST) begin
                    state_nx = S_DRAIN;
                    t_nx     = '0;
                    drain_nx = 1'b0;
                end else begin
                    t_nx = t + CW'(1);
                end
            end
            S_DRAIN: begin
                if (drain_cnt) state_nx = S_DONE;
                else           drain_nx = 1'b1;
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    assign run      = (state == S_RUN);
    assign bus.busy = (state != S_IDLE);
    assign bus.done = (state == S_DONE);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        skew_lane #(
            .IDX (i),
            .LEN (LEN),
            .DW  (DW),
            .CW  (CW)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .run       (run),
            .t         (t),
            .fifo_data (bus.fifo_data[i*DW +: DW]),
            .rd_en     (rd_en_w[i]),
            .arr_data  (arr_data_w[i*DW +: DW]),
            .arr_valid (arr_valid_w[i])
        );
    end

    assign bus.rd_en     = rd_en_w;
    assign bus.arr_valid = arr_valid_w;
    assign bus.arr_data  = arr_data_w;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for the skew feeder: a FIFO model feeds the default-size instance,
// a scoreboard checks every operand leaving it, and a per-cycle model of the
// run schedule checks rd_en/arr_valid/busy/done. A second, small instance
// covers non-default geometry.
module tb_systolic_skew_feeder;

    localparam int LANES = 5;
    localparam int DW    = 32;
    localparam int LEN   = 5;

    localparam int S_LANES = 3;
    localparam int S_LEN   = 2;

    typedef struct packed {
        logic [7:0] rd_en;
        logic [7:0] valid;
        logic       busy;
        logic       done;
    } exp_t;

    logic clk;
    logic rst;

    systolic_skew_feeder_if #(.LANES(LANES),   .DW(DW)) bus ();
    systolic_skew_feeder_if #(.LANES(S_LANES), .DW(DW)) bus_s ();

    systolic_skew_feeder #(.LANES(LANES), .DW(DW), .LEN(LEN), .CW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    systolic_skew_feeder #(.LANES(S_LANES), .DW(DW), .LEN(S_LEN), .CW(3)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    // Expected schedule relative to c0 (first RUN cycle).
    function automatic exp_t model(input int c, input int lanes, input int len);
        exp_t e;
        int   rl;
        e  = '0;
        rl = len + lanes - 1 + 3;
        for (int i = 0; i < lanes; i++) begin
            e.rd_en[i] = (c >= i) && (c < i + len);
            e.valid[i] = (c >= i + 2) && (c < i + len + 2);
        end
        e.busy = (c >= 0) && (c < rl);
        e.done = (c == rl - 1);
        return e;
    endfunction

    // FIFO model and scoreboard for the default instance.
    logic [DW-1:0] fifo_mem [LANES][LEN];
    int            fifo_ptr [LANES];
    logic [DW-1:0] exp_q    [LANES][$];

    task automatic load_fifos(input int run_id);
        logic [DW-1:0] v;
        for (int i = 0; i < LANES; i++) begin
            for (int k = 0; k < LEN; k++) begin
                v = DW'(100 * run_id + 10 * i + k + 1);
                fifo_mem[i][k] = v;
                exp_q[i].push_back(v);
            end
            fifo_ptr[i] = 0;
        end
    endtask

    task automatic check_drained(input string tag);
        for (int i = 0; i < LANES; i++)
            check($sformatf("%s lane%0d left", tag, i), 64'(exp_q[i].size()), 64'd0);
    endtask

    // FIFO read model: data for a read issued in cycle n appears in cycle n+1.
    initial begin
        logic [LANES-1:0] en;
        bus.fifo_data = {LANES{32'hA5A5_A5A5}};
        for (int i = 0; i < LANES; i++) fifo_ptr[i] = 0;
        forever begin
            @(negedge clk);
            en = bus.rd_en;
            @(posedge clk);
            #1;
            for (int i = 0; i < LANES; i++) begin
                if (en[i]) begin
                    if (fifo_ptr[i] < LEN) bus.fifo_data[i*DW +: DW] = fifo_mem[i][fifo_ptr[i]];
                    else                   bus.fifo_data[i*DW +: DW] = 32'hDEAD_BEEF;
                    fifo_ptr[i]++;
                end
            end
        end
    end

    // Output monitor: every valid operand must match the next expected value,
    // every invalid slot must be zero.
    initial begin
        logic [DW-1:0] d;
        forever begin
            @(negedge clk);
            for (int i = 0; i < LANES; i++) begin
                d = bus.arr_data[i*DW +: DW];
                if (bus.arr_valid[i]) begin
                    check($sformatf("lane%0d sb entry", i), 64'(exp_q[i].size() > 0), 64'd1);
                    if (exp_q[i].size() > 0)
                        check($sformatf("lane%0d data", i), 64'(d), 64'(exp_q[i].pop_front()));
                end else begin
                    check($sformatf("lane%0d pad", i), 64'(d), 64'd0);
                end
            end
        end
    end

    // Follows a run of the default instance from c0, checking control outputs
    // each cycle and driving start per cycle from start_at.
    task automatic follow_run(input logic [15:0] start_at, input int ncyc, input int com_drop);
        exp_t e;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            e = model(c, LANES, LEN);
            check($sformatf("rd_en c%0d", c),     64'(bus.rd_en),     64'(e.rd_en));
            check($sformatf("arr_valid c%0d", c), 64'(bus.arr_valid), 64'(e.valid));
            check($sformatf("busy c%0d", c),      64'(bus.busy),      64'(e.busy));
            check($sformatf("done c%0d", c),      64'(bus.done),      64'(e.done));
            bus.start = start_at[c];
            if (c == com_drop) bus.com = 1'b0;
        end
    endtask

    initial begin
        exp_t e;
        rst             = 1'b1;
        bus.start       = 1'b0;
        bus.com         = 1'b0;
        bus_s.start     = 1'b0;
        bus_s.com       = 1'b1;
        bus_s.fifo_data = {32'h0000_0102, 32'h0000_0101, 32'h0000_0100};

        // Reset state
        repeat (2) @(negedge clk);
        check("reset rd_en",     64'(bus.rd_en),     64'd0);
        check("reset arr_valid", 64'(bus.arr_valid), 64'd0);
        check("reset arr_data",  64'(bus.arr_data),  64'd0);
        check("reset busy",      64'(bus.busy),      64'd0);
        check("reset done",      64'(bus.done),      64'd0);
        check("reset s busy",    64'(bus_s.busy),    64'd0);
        rst = 1'b0;

        // Basic run: com already high, one start pulse
        @(negedge clk);
        load_fifos(0);
        bus.com   = 1'b1;
        bus.start = 1'b1;
        follow_run(16'h0000, 13, -1);
        check_drained("basic");

        // Start before com: WAIT_COM for 7 cycles, com dropped again mid-run
        bus.com = 1'b0;
        load_fifos(1);
        @(negedge clk);
        bus.start = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            check($sformatf("wait busy k%0d", k),  64'(bus.busy),  64'd1);
            check($sformatf("wait rd_en k%0d", k), 64'(bus.rd_en), 64'd0);
            bus.start = 1'b0;
            if (k == 7) bus.com = 1'b1;
        end
        follow_run(16'h0000, 13, 1);
        check_drained("wait_com");

        // Start while busy (c3 and held from DONE), then accepted in IDLE
        bus.com = 1'b1;
        load_fifos(2);
        @(negedge clk);
        bus.start = 1'b1;
        follow_run(16'h1808, 13, -1);
        check_drained("busy_start");
        load_fifos(3);
        follow_run(16'h0000, 13, -1);
        check_drained("back_to_back");

        // Mid-run reset at c5, then a clean full run
        load_fifos(4);
        @(negedge clk);
        bus.start = 1'b1;
        follow_run(16'h0000, 6, -1);
        #2 rst = 1'b1;
        #1;
        check("mid rst rd_en",     64'(bus.rd_en),     64'd0);
        check("mid rst arr_valid", 64'(bus.arr_valid), 64'd0);
        check("mid rst arr_data",  64'(bus.arr_data),  64'd0);
        check("mid rst busy",      64'(bus.busy),      64'd0);
        check("mid rst done",      64'(bus.done),      64'd0);
        for (int i = 0; i < LANES; i++) exp_q[i].delete();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("rst hold done k%0d", k), 64'(bus.done), 64'd0);
            check($sformatf("rst hold busy k%0d", k), 64'(bus.busy), 64'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        load_fifos(5);
        bus.start = 1'b1;
        follow_run(16'h0000, 13, -1);
        check_drained("after_reset");

        // Non-default geometry: LANES=3, LEN=2
        @(negedge clk);
        bus_s.start = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            e = model(c, S_LANES, S_LEN);
            check($sformatf("s rd_en c%0d", c),     64'(bus_s.rd_en),     64'(e.rd_en));
            check($sformatf("s arr_valid c%0d", c), 64'(bus_s.arr_valid), 64'(e.valid));
            check($sformatf("s busy c%0d", c),      64'(bus_s.busy),      64'(e.busy));
            check($sformatf("s done c%0d", c),      64'(bus_s.done),      64'(e.done));
            for (int i = 0; i < S_LANES; i++)
                check($sformatf("s lane%0d data c%0d", i, c),
                      64'(bus_s.arr_data[i*DW +: DW]),
                      e.valid[i] ? 64'(32'h100 + i) : 64'd0);
            bus_s.start = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
